// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SEL_W    = 2;

  // Instruction opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // Control FSM states; encoding is visible on the debug port and must not move
  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_HALT   = 4'd15
  } state_e;

  // Codes consumed by the ALU control decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B selects
  localparam logic [SEL_W-1:0] ALUSRCB_RT      = 2'd0;
  localparam logic [SEL_W-1:0] ALUSRCB_FOUR    = 2'd1;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM     = 2'd2;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM_SH2 = 2'd3;

  // Next-PC selects
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

  // Write-register selects
  localparam logic [SEL_W-1:0] REGDST_RT = 2'd0;
  localparam logic [SEL_W-1:0] REGDST_RD = 2'd1;

  // States that hold the memory port and wait on MemReady
  function automatic logic is_mem_wait_state(input state_e st);
    return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
  endfunction

  // Opcodes the decoder knows how to sequence
  function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for memory accesses; expired_o is combinational and
// flags the waiting cycle whose edge would bring the count to MAX_WAIT.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count waiting cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  // Timeout compare on the last permitted waiting cycle
  always_comb begin
    expired_o = 1'b0;
    if (en_i && (cnt_q == WAIT_W'(MAX_WAIT - 1))) begin
      expired_o = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS-subset core: sequences fetch,
// decode, execute, memory and writeback and drives every datapath control.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic [SEL_W-1:0]    RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [SEL_W-1:0]    ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [SEL_W-1:0]    PCSource,
  output logic [STATE_W-1:0]  State,
  output logic                Fault
);

  state_e state_q;
  state_e state_d;
  logic   fault_q;
  logic   fault_d;

  logic   wait_en;
  logic   wait_clear;
  logic   wait_expired;

  // Count only while parked on the memory port without a response; any other
  // cycle clears, so each of FETCH/MEMRD/MEMWR is entered with a zero count.
  always_comb begin
    wait_en    = is_mem_wait_state(state_q) && !MemReady;
    wait_clear = Rst || !wait_en;
  end

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk_i     (Clk),
    .clear_i   (wait_clear),
    .en_i      (wait_en),
    .expired_o (wait_expired)
  );

  // State and sticky fault registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_RESET;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic and Moore control decode
  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = REGDST_RT;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        // PC+4 through the ALU; IR and PC load only on the completing cycle
        MemRead = 1'b1;
        IorD    = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = ALUSRCB_FOUR;
        ALUOp   = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_DECODE: begin
        // Branch target precompute while the opcode is decoded
        ALUSrcA = 1'b0;
        ALUSrcB = ALUSRCB_IMM_SH2;
        ALUOp   = ALUOP_ADD;
        if (!is_legal_opcode(Opcode)) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else if (Opcode == OP_RTYPE) begin
          state_d = ST_EXEC;
        end else if ((Opcode == OP_LW) || (Opcode == OP_SW)) begin
          state_d = ST_MEMADR;
        end else if (Opcode == OP_BEQ) begin
          state_d = ST_BRANCH;
        end else if (Opcode == OP_J) begin
          state_d = ST_JUMP;
        end else begin
          state_d = ST_ADDIEX;
        end
      end

      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        ALUOp   = ALUOP_ADD;
        state_d = (Opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end

      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) begin
          state_d = ST_MEMWB;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_MEMWB: begin
        RegDst   = REGDST_RT;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          state_d = ST_FETCH;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end
      end

      ST_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_RT;
        ALUOp   = ALUOP_FUNCT;
        state_d = ST_RWB;
      end

      ST_RWB: begin
        RegDst   = REGDST_RD;
        MemtoReg = 1'b0;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = ALUSRCB_RT;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        state_d     = ST_FETCH;
      end

      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = ST_FETCH;
      end

      ST_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        ALUOp   = ALUOP_ADD;
        state_d = ST_ADDIWB;
      end

      ST_ADDIWB: begin
        RegDst   = REGDST_RT;
        MemtoReg = 1'b0;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_HALT: begin
        // Parked until reset; only Fault remains visible
        state_d = ST_HALT;
      end

      default: begin
        // Unused encodings recover through RESET
        state_d = ST_RESET;
      end
    endcase
  end

  // Debug and status outputs
  always_comb begin
    State = state_q;
    Fault = fault_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised scoreboard bench for multicycle_control: the driver walks an
// instruction-level model and queues the expected controls for each cycle;
// a monitor on the falling edge pops and compares against the DUT.
module tb_multicycle_control;

  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned WAIT_W   = 8;

  localparam logic [5:0] O_RTYPE = 6'b000000;
  localparam logic [5:0] O_LW    = 6'b100011;
  localparam logic [5:0] O_SW    = 6'b101011;
  localparam logic [5:0] O_BEQ   = 6'b000100;
  localparam logic [5:0] O_J     = 6'b000010;
  localparam logic [5:0] O_ADDI  = 6'b001000;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic [1:0] rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] pcs;
    logic       flt;
  } ctl_t;

  logic       Clk;
  logic       Rst;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic       Fault;

  multicycle_control #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .Fault       (Fault)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  ctl_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   m_fault = 1'b0;
  bit   m_halt  = 1'b0;

  // Expected controls for one cycle spent in a given phase
  function automatic ctl_t exp_of(input int st, input bit mr, input bit flt);
    ctl_t e;
    e     = '0;
    e.st  = 4'(st);
    e.flt = flt;
    case (st)
      1:  begin e.mrd = 1'b1; e.asb = 2'd1; e.irw = mr; e.pcw = mr; end
      2:  begin e.asb = 2'd3; end
      3:  begin e.asa = 1'b1; e.asb = 2'd2; end
      4:  begin e.mrd = 1'b1; e.iord = 1'b1; end
      5:  begin e.m2r = 1'b1; e.rw = 1'b1; end
      6:  begin e.mwr = 1'b1; e.iord = 1'b1; end
      7:  begin e.asa = 1'b1; e.aop = 2'd2; end
      8:  begin e.rdst = 2'd1; e.rw = 1'b1; end
      9:  begin e.asa = 1'b1; e.aop = 2'd1; e.pcwc = 1'b1; e.pcs = 2'd1; end
      10: begin e.pcw = 1'b1; e.pcs = 2'd2; end
      11: begin e.asa = 1'b1; e.asb = 2'd2; end
      12: begin e.rw = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return (op == O_RTYPE) || (op == O_LW) || (op == O_SW) ||
           (op == O_BEQ) || (op == O_J) || (op == O_ADDI);
  endfunction

  // One clock cycle: apply inputs, queue the expected response, advance
  task automatic step(input bit rst, input logic [5:0] op, input bit mr, input int st);
    Rst      = rst;
    Opcode   = op;
    MemReady = mr;
    exp_q.push_back(exp_of(st, mr, m_fault));
    @(posedge Clk);
    #1;
  endtask

  // A memory phase that sees nwait not-ready cycles before completing
  task automatic mem_phase(input int st, input int nwait, input logic [5:0] op);
    for (int w = 0; ; w++) begin
      bit mr;
      mr = (w >= nwait);
      step(1'b0, op, mr, st);
      if (mr) break;
      if (w + 1 == int'(MAX_WAIT)) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
        break;
      end
    end
  endtask

  // Execute one instruction from FETCH back to the next FETCH
  task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
    mem_phase(1, fw, op);
    if (m_halt) return;
    step(1'b0, op, 1'($urandom_range(0, 1)), 2);
    if (!legal(op)) begin
      m_fault = 1'b1;
      m_halt  = 1'b1;
      return;
    end
    case (op)
      O_RTYPE: begin
        step(1'b0, op, 1'($urandom_range(0, 1)), 7);
        step(1'b0, op, 1'($urandom_range(0, 1)), 8);
      end
      O_LW: begin
        step(1'b0, op, 1'($urandom_range(0, 1)), 3);
        mem_phase(4, mw, op);
        if (m_halt) return;
        step(1'b0, op, 1'($urandom_range(0, 1)), 5);
      end
      O_SW: begin
        step(1'b0, op, 1'($urandom_range(0, 1)), 3);
        mem_phase(6, mw, op);
      end
      O_BEQ: step(1'b0, op, 1'($urandom_range(0, 1)), 9);
      O_J:   step(1'b0, op, 1'($urandom_range(0, 1)), 10);
      default: begin
        step(1'b0, op, 1'($urandom_range(0, 1)), 11);
        step(1'b0, op, 1'($urandom_range(0, 1)), 12);
      end
    endcase
  endtask

  // Reset asserted while in cur_state for n cycles, then one RESET cycle
  task automatic reset_seq(input int cur_state, input int n, input bit mr);
    step(1'b1, 6'($urandom), mr, cur_state);
    m_fault = 1'b0;
    m_halt  = 1'b0;
    for (int i = 1; i < n; i++) step(1'b1, 6'($urandom), 1'($urandom_range(0, 1)), 0);
    step(1'b0, 6'($urandom), 1'($urandom_range(0, 1)), 0);
  endtask

  task automatic halt_then_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'($urandom), 1'($urandom_range(0, 1)), 15);
    reset_seq(15, 2, 1'($urandom_range(0, 1)));
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge Clk) begin
    cyc++;
    if (exp_q.size() != 0) begin
      ctl_t e;
      ctl_t g;
      e      = exp_q.pop_front();
      g.st   = State;
      g.pcw  = PCWrite;
      g.pcwc = PCWriteCond;
      g.iord = IorD;
      g.mrd  = MemRead;
      g.mwr  = MemWrite;
      g.irw  = IRWrite;
      g.m2r  = MemtoReg;
      g.rdst = RegDst;
      g.rw   = RegWrite;
      g.asa  = ALUSrcA;
      g.asb  = ALUSrcB;
      g.aop  = ALUOp;
      g.pcs  = PCSource;
      g.flt  = Fault;
      n_chk++;
      if (g === e) begin
        n_pass++;
      end else begin
        $display("FAIL ctl cyc=%0d exp_state=%0d got=%h exp=%h (st pcw pcwc iord mrd mwr irw m2r rdst rw asa asb aop pcs flt)",
                 cyc, e.st, g, e);
      end
    end
  end

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops = '{O_RTYPE, O_LW, O_SW, O_BEQ, O_J, O_ADDI};
    Rst = 1'b1;
    Opcode = '0;
    MemReady = 1'b1;
    @(posedge Clk);
    #1;
    // Reset held three edges, then release with memory always ready
    step(1'b1, 6'd0, 1'b1, 0);
    step(1'b1, 6'd0, 1'b1, 0);
    step(1'b0, 6'd0, 1'b1, 0);

    // Directed: each instruction class with zero-wait memory
    do_instr(O_RTYPE, 0, 0);
    do_instr(O_LW, 0, 3);
    do_instr(O_BEQ, 0, 0);
    do_instr(O_J, 0, 0);
    do_instr(O_SW, 0, 0);
    do_instr(O_ADDI, 0, 0);

    // Longest legal wait: ready arrives on the cycle that would otherwise time out
    do_instr(O_LW, int'(MAX_WAIT) - 1, int'(MAX_WAIT) - 1);
    do_instr(O_SW, 2, int'(MAX_WAIT) - 1);

    // Timeout while fetching; late MemReady must not revive the core
    do_instr(O_RTYPE, int'(MAX_WAIT) + 5, 0);
    halt_then_reset(5);

    // Timeout during a load and during a store
    do_instr(O_LW, 1, int'(MAX_WAIT) + 2);
    halt_then_reset(3);
    do_instr(O_SW, 0, int'(MAX_WAIT) + 2);
    halt_then_reset(3);

    // Illegal opcode
    do_instr(6'b111111, 0, 0);
    halt_then_reset(4);

    // Reset in the middle of a store
    mem_phase(1, 0, O_SW);
    step(1'b0, O_SW, 1'b0, 2);
    step(1'b0, O_SW, 1'b0, 3);
    step(1'b0, O_SW, 1'b0, 6);
    step(1'b0, O_SW, 1'b0, 6);
    reset_seq(6, 1, 1'b0);

    // Randomised instruction stream with occasional stalls and illegal opcodes
    for (int i = 0; i < 120; i++) begin
      logic [5:0] op;
      int fw;
      int mw;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      if ($urandom_range(0, 29) == 0) mw = int'(MAX_WAIT) + 1;
      do_instr(op, fw, mw);
      if (m_halt) halt_then_reset(int'($urandom_range(1, 3)));
    end

    // Drain: every queued expectation must have been consumed
    @(negedge Clk);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle variant of the unpipelined MIPS-subset processor.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU, one memory port and the register file.
- Drives ALUOp into the existing ALU control decoder and all datapath mux selects and write enables.
- Waits on a memory-ready handshake, with a bounded wait that halts the core on timeout.

Parameters:
- MAX_WAIT, 15: cycles a memory access may wait for MemReady before Fault. Legal range 1..255.
- WAIT_W, 8: width of the wait counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous reset, active high
- Opcode  in  6  instruction[31:26] from the IR
- MemReady  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load when the ALU Zero flag is set (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- RegDst  out  2  write register select: 0 = rt, 1 = rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU operand A select: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU operand B select: 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- ALUOp  out  2  to ALU control: 00 = add, 01 = subtract, 10 = decode funct
- PCSource  out  2  next-PC select: 0 = ALU, 1 = ALUOut, 2 = jump target
- State  out  4  current state, for debug
- Fault  out  1  sticky flag: memory timeout or illegal opcode

Behaviour:
- States (encoding fixed): RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=15.
- Reset:
  - Rst high at a clock edge → State=RESET, wait counter=0, Fault=0.
  - RESET drives every output to 0.
  - Reset mid-access abandons the access; no write enable fires in the cycle after.
- RESET → FETCH on the first edge with Rst low.
- Outputs are Moore decodes of State, except IRWrite and PCWrite in FETCH, which are qualified by MemReady.
- Any control output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite=PCWrite=MemReady.
  - MemReady=1 → DECODE; otherwise stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by Opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDIEX.
  - Any other Opcode → set Fault, go to HALT.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw (Opcode held in the IR).
- MEMRD: MemRead=1, IorD=1. Stay until MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until MemReady, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=2. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle the FSM stays in one of those states with MemReady=0.
  - Counter reaching MAX_WAIT with MemReady still 0 → Fault=1 and HALT on that edge.
  - MemReady=1 in that same cycle wins: normal transition, no Fault.
- HALT: all outputs 0 except Fault. Only Rst exits.
- Cycle counts with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - state encodings;
  - ALUOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - ALUSrcB and PCSource select codes.
- One sub-module, mem_wait_timer, contains the wait counter and the timeout compare. Inputs: clear, count enable. Output: expired.

Test Plan:
- Rst held 3 cycles, then released, MemReady tied 1 → State 0 for those cycles; all outputs 0; then State=1, MemRead=1, IRWrite=1, PCWrite=1.
- R-type (Opcode 000000), MemReady=1 → states 1,2,7,8,1; ALUOp=10 in EXEC; RegWrite=1 with RegDst=1 only in RWB.
- lw (Opcode 100011) with MemReady low for 3 cycles in MEMRD → MEMRD held 4 cycles with MemRead=1, IorD=1; then MEMWB with RegWrite=1, MemtoReg=1; Fault stays 0.
- beq (Opcode 000100) then j (Opcode 000010) → BRANCH: ALUOp=01, PCWriteCond=1, PCSource=1. JUMP: PCWrite=1, PCSource=2. Each returns to FETCH.
- MemReady held 0 in FETCH, MAX_WAIT=15 → Fault=1 and State=15 on the 15th waiting edge. MemReady rising later has no effect; Rst clears Fault and returns to RESET.
- Illegal Opcode 111111 in DECODE → Fault=1, State=15. Rst asserted mid-MEMWR → next cycle MemWrite=0 and State=0.
